// File: rtl/lstm_ctrl_pkg.sv
// Shared types and default sizing for the LSTM run-level sequencer.
// Imported by the sequencer top and its watchdog.
package lstm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FEED  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam int DEF_TIMESTEP    = 7;
  localparam int DEF_LAYR1_INPUT = 53;
  localparam int DEF_LAYR2_CELL  = 8;

  function automatic int drain_len(int ts, int cells);
    return ts * cells;
  endfunction

  localparam int DEF_DRAIN_LEN =
    drain_len(DEF_TIMESTEP, DEF_LAYR2_CELL);

endpackage

// File: rtl/lstm_run_ctrl_wdog.sv
// Loadable cycle counter with clear/enable and terminal-count flag.
// Used as the per-timestep WAIT watchdog.
module lstm_step_wdog
  import lstm_ctrl_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int TERMINAL = 4095
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/lstm_run_ctrl.sv
// Run-level sequencer: clear, per-step input feed and wait,
// then drain of layer-2 h words over a valid/ready port.
module lstm_run_ctrl
  import lstm_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int TIMESTEP    = DEF_TIMESTEP,
  parameter int LAYR1_INPUT = DEF_LAYR1_INPUT,
  parameter int LAYR2_CELL  = DEF_LAYR2_CELL,
  parameter int TIMEOUT     = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  step_done,
  output logic                  rst_dp,
  output logic                  en,
  output logic [ADDR_WIDTH-1:0] addr_x1,
  output logic                  x_valid,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            t_idx,
  output logic                  busy,
  output logic                  finish,
  output logic                  err
);

  localparam int IW   = $clog2(LAYR1_INPUT);
  localparam int WW   = $clog2(TIMEOUT);
  localparam int DLEN = drain_len(TIMESTEP, LAYR2_CELL);

  state_t                state;
  logic [IW-1:0]         i;
  logic [ADDR_WIDTH-1:0] base;
  logic [WW-1:0]         wd_count;
  logic                  wd_tc;

  // Counter sits at zero outside WAIT, so it counts WAIT cycles from 0.
  lstm_step_wdog #(
    .WIDTH    (WW),
    .TERMINAL (TIMEOUT - 1)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (abort),
    .load     (state != ST_WAIT),
    .load_val ('0),
    .en       (state == ST_WAIT),
    .count    (wd_count),
    .tc       (wd_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      i         <= '0;
      base      <= '0;
      rst_dp    <= 1'b0;
      en        <= 1'b0;
      addr_x1   <= '0;
      x_valid   <= 1'b0;
      addr_out  <= '0;
      out_valid <= 1'b0;
      t_idx     <= '0;
      busy      <= 1'b0;
      finish    <= 1'b0;
      err       <= 1'b0;
    end else if (abort) begin
      state     <= ST_IDLE;
      i         <= '0;
      base      <= '0;
      rst_dp    <= 1'b0;
      en        <= 1'b0;
      addr_x1   <= '0;
      x_valid   <= 1'b0;
      addr_out  <= '0;
      out_valid <= 1'b0;
      t_idx     <= '0;
      busy      <= 1'b0;
      finish    <= 1'b0;
    end else begin
      rst_dp <= 1'b0;
      finish <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_CLR;
            rst_dp <= 1'b1;
            busy   <= 1'b1;
            err    <= 1'b0;
          end
        end
        ST_CLR: begin
          state   <= ST_FEED;
          en      <= 1'b1;
          x_valid <= 1'b1;
          addr_x1 <= '0;
          base    <= '0;
          i       <= '0;
          t_idx   <= '0;
        end
        ST_FEED: begin
          if (i == IW'(LAYR1_INPUT - 1)) begin
            state   <= ST_WAIT;
            x_valid <= 1'b0;
          end else begin
            i       <= i + IW'(1);
            addr_x1 <= base + ADDR_WIDTH'(i) + ADDR_WIDTH'(1);
          end
        end
        ST_WAIT: begin
          if (step_done) begin
            state <= ST_NEXT;
            en    <= 1'b0;
          end else if (wd_tc) begin
            state <= ST_IDLE;
            err   <= 1'b1;
            en    <= 1'b0;
            busy  <= 1'b0;
            t_idx <= '0;
          end
        end
        ST_NEXT: begin
          if (t_idx == 3'(TIMESTEP - 1)) begin
            state     <= ST_DRAIN;
            out_valid <= 1'b1;
            addr_out  <= '0;
          end else begin
            state   <= ST_FEED;
            t_idx   <= t_idx + 3'd1;
            base    <= base + ADDR_WIDTH'(LAYR1_INPUT);
            addr_x1 <= base + ADDR_WIDTH'(LAYR1_INPUT);
            i       <= '0;
            en      <= 1'b1;
            x_valid <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (addr_out == ADDR_WIDTH'(DLEN - 1)) begin
              state     <= ST_DONE;
              out_valid <= 1'b0;
              finish    <= 1'b1;
            end else begin
              addr_out <= addr_out + ADDR_WIDTH'(1);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          t_idx <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
